// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants and state encoding for the serial comparator
// Purpose: digit width and FSM state encoding used by the serial comparator
//          and its 2-bit digit comparator.
// Ports: none (package).
package cmp_pkg;

  localparam int DIGIT_W = 2;

  // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/magnitude_comparator_using_decoder.sv
// rtl/magnitude_comparator_using_decoder.sv - combinational 2-bit comparator built from one-hot decoders
// Purpose: compares two unsigned 2-bit digits. Each digit is decoded to a
//          one-hot vector; gt/eq/lt are the OR of the matching decode pairs.
// Ports:
//   A   in  2  digit A, unsigned
//   B   in  2  digit B, unsigned
//   gt  out 1  A > B
//   eq  out 1  A == B
//   lt  out 1  A < B
module magnitude_comparator_using_decoder
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] A,
  input  logic [DIGIT_W-1:0] B,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  localparam int N = 1 << DIGIT_W;

  logic [N-1:0] dec_a;
  logic [N-1:0] dec_b;

  always_comb begin
    dec_a = N'(1) << A;
    dec_b = N'(1) << B;
    gt    = 1'b0;
    eq    = 1'b0;
    lt    = 1'b0;
    // Exactly one (i, j) pair is active; its relative position picks the output.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i > j) begin
          gt = gt | (dec_a[i] & dec_b[j]);
        end else if (i == j) begin
          eq = eq | (dec_a[i] & dec_b[j]);
        end else begin
          lt = lt | (dec_a[i] & dec_b[j]);
        end
      end
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - multi-cycle MSB-first unsigned magnitude comparator
// Purpose: compares two WIDTH-bit unsigned operands one 2-bit digit per clock,
//          MSB first, stopping at the first unequal digit. Result is held
//          from the done pulse until the next accepted start.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      asynchronous active-high reset
//   start  in  1      request, sampled only while idle
//   a      in  WIDTH  operand A, captured on accepted start
//   b      in  WIDTH  operand B, captured on accepted start
//   busy   out 1      operation in progress (not idle)
//   done   out 1      one-cycle result-valid pulse
//   gt     out 1      A > B (registered)
//   eq     out 1      A == B (registered)
//   lt     out 1      A < B (registered)
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int D     = WIDTH / DIGIT_W;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             dig_gt;
  logic             dig_eq;
  logic             dig_lt;

  magnitude_comparator_using_decoder u_digit_cmp (
    .A  (sa[WIDTH-1 -: DIGIT_W]),
    .B  (sb[WIDTH-1 -: DIGIT_W]),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CMP;
      CMP:  if (dig_gt || dig_lt || (cnt == '0)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      gt <= 1'b0;
      eq <= 1'b0;
      lt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cnt <= CNT_W'(D - 1);
            gt  <= 1'b0;
            eq  <= 1'b0;
            lt  <= 1'b0;
          end
        end
        CMP: begin
          // On the last digit an equal compare already reads 010, so every
          // exit latches the digit comparator directly.
          if (dig_gt || dig_lt || (cnt == '0)) begin
            gt <= dig_gt;
            eq <= dig_eq;
            lt <= dig_lt;
          end else begin
            sa  <= sa << DIGIT_W;
            sb  <= sb << DIGIT_W;
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy4, done4, gt4, eq4, lt4;

  bit         sel4;
  logic       m_busy, m_done, m_gt, m_eq, m_lt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  serial_magnitude_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  assign m_busy = sel4 ? busy4 : busy8;
  assign m_done = sel4 ? done4 : done8;
  assign m_gt   = sel4 ? gt4   : gt8;
  assign m_eq   = sel4 ? eq4   : eq8;
  assign m_lt   = sel4 ? lt4   : lt8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result code {gt,eq,lt} from plain unsigned comparison.
  function automatic int ref_res(input logic [7:0] av, input logic [7:0] bv);
    if (av > bv) return 4;
    if (av == bv) return 2;
    return 1;
  endfunction

  // Reference: 1-based index (from the MSB) of the first differing 2-bit digit,
  // or the digit count when the operands are equal.
  function automatic int ref_lat(input logic [7:0] av, input logic [7:0] bv, input int w);
    for (int j = 1; j <= w / 2; j++) begin
      if (((av >> (w - 2 * j)) & 8'd3) != ((bv >> (w - 2 * j)) & 8'd3)) return j;
    end
    return w / 2;
  endfunction

  function automatic int res_now();
    return int'({m_gt, m_eq, m_lt});
  endfunction

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic st);
    if (sel4) begin
      a4 = av[3:0];
      b4 = bv[3:0];
      start4 = st;
    end else begin
      a8 = av;
      b8 = bv;
      start8 = st;
    end
  endtask

  // Called 1 time unit after an edge with the DUT idle.
  // mode 0: quiet; 1: random a/b/start noise while busy; 2: start with FF/00 while busy.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int mode, input string tag);
    int w;
    int lat;
    int exp_r;
    int exp_l;
    w = sel4 ? 4 : 8;
    exp_r = ref_res(av, bv);
    exp_l = ref_lat(av, bv, w);
    lat = 0;
    drive(av, bv, 1'b1);
    @(posedge clk); #1;
    check({tag, " busy_after_start"}, 32'(m_busy), 1);
    if (mode == 1) drive(8'($urandom), 8'($urandom), 1'($urandom));
    else if (mode == 2) drive(8'hFF, 8'h00, 1'b1);
    else drive(av, bv, 1'b0);
    for (int k = 1; k <= w / 2 + 2; k++) begin
      @(posedge clk); #1;
      if (m_done) begin
        lat = k;
        drive(av, bv, 1'b0);
        break;
      end
      check({tag, " busy_in_cmp"}, 32'(m_busy), 1);
      if (mode == 1) drive(8'($urandom), 8'($urandom), 1'($urandom));
      else drive(av, bv, 1'b0);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_l));
    check({tag, " result"}, 32'(res_now()), 32'(exp_r));
    check({tag, " busy_in_done"}, 32'(m_busy), 1);
    @(posedge clk); #1;
    check({tag, " single_done"}, 32'(m_done), 0);
    check({tag, " idle_after"}, 32'(m_busy), 0);
    check({tag, " result_held"}, 32'(res_now()), 32'(exp_r));
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    sel4 = 1'b0;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;

    // Reset state
    #12;
    check("rst busy8", 32'(busy8), 0);
    check("rst done8", 32'(done8), 0);
    check("rst res8", 32'({gt8, eq8, lt8}), 0);
    check("rst res4", 32'({busy4, done4, gt4, eq4, lt4}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle no start", 32'({busy8, done8}), 0);
    end

    // MSB digit differs: one-cycle compare
    run_op(8'h80, 8'h7F, 0, "msb_gt");

    // Reset asserted mid-cycle clears the held result at once
    #3;
    rst = 1'b1;
    #1;
    check("async rst res", 32'({gt8, eq8, lt8}), 0);
    check("async rst busy", 32'({busy8, done8}), 0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'hA5, 8'hA5, 0, "eq_a5");
    run_op(8'h12, 8'h13, 0, "lt_lsb");

    // start while busy is ignored
    run_op(8'h10, 8'h20, 2, "busy_start");

    // Reset in the 2nd CMP cycle: no done, result cleared
    drive(8'h03, 8'h03, 1'b1);
    @(posedge clk); #1;
    drive(8'h03, 8'h03, 1'b0);
    @(posedge clk); #1;
    check("midop busy", 32'(busy8), 1);
    #1;
    rst = 1'b1;
    #1;
    check("midop rst res", 32'({gt8, eq8, lt8}), 0);
    check("midop rst flags", 32'({busy8, done8}), 0);
    #2;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("midop no done", 32'({busy8, done8}), 0);
    end
    run_op(8'h03, 8'h03, 0, "after_rst");

    // Randomized operands, biased so equal leading digits are common
    for (int n = 0; n < 150; n++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (8'd1 << $urandom_range(0, 7));
        2: rb = ra ^ (8'd3 << (2 * $urandom_range(0, 3)));
        default: rb = 8'($urandom);
      endcase
      run_op(ra, rb, n % 2, "rand8");
    end

    // WIDTH=4: every pair, back to back
    sel4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(8'(i), 8'(j), 0, "exh4");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
